// File: rtl/jtopl_mmr_pkg.sv
// jtopl_mmr_pkg
// Shared definitions for the OPL2 host register decoder: register-map base
// addresses, the default operator sweep length and the update-strobe index.
// Also holds the channel -> (group, subslot) helpers used by the decoder.
package jtopl_mmr_pkg;

  // Operator slots per sample; a strobe is held for this many cen ticks.
  localparam int SWEEP_DEF = 18;

  // Register-map base addresses
  localparam logic [7:0] REG_MULT    = 8'h20;
  localparam logic [7:0] REG_KSL_TL  = 8'h40;
  localparam logic [7:0] REG_AR_DR   = 8'h60;
  localparam logic [7:0] REG_SL_RR   = 8'h80;
  localparam logic [7:0] REG_FNUM_LO = 8'hA0;
  localparam logic [7:0] REG_FNUM_HI = 8'hB0;
  localparam logic [7:0] REG_FBCON   = 8'hC0;

  // Update-strobe index; the value is also the bit position in the one-hot
  // strobe vector.
  typedef enum logic [2:0] {
    STB_MULT   = 3'd0,
    STB_KSL_TL = 3'd1,
    STB_AR_DR  = 3'd2,
    STB_SL_RR  = 3'd3,
    STB_FNUM   = 3'd4,
    STB_FBCON  = 3'd5
  } stb_e;

  localparam int NSTB = 6;

  // Channel 0..8 -> group (ch/3)
  function automatic logic [1:0] ch_group(input logic [3:0] ch);
    if (ch < 4'd3)      return 2'd0;
    else if (ch < 4'd6) return 2'd1;
    else                return 2'd2;
  endfunction

  // Channel 0..8 -> subslot (ch%3)
  function automatic logic [2:0] ch_sub(input logic [3:0] ch);
    case (ch)
      4'd0, 4'd3, 4'd6: return 3'd0;
      4'd1, 4'd4, 4'd7: return 3'd1;
      default:          return 3'd2;
    endcase
  endfunction

endpackage

// File: rtl/jtopl_mmr_dec.sv
// jtopl_mmr_dec
// Combinational decode of the selected register address.
// Ports:
//   sel_reg_i    selected register address (last address-port write)
//   valid_o      address maps to an operator/channel update strobe
//   fnum_latch_o address is in the F-number low-byte range (0xA0-0xA8)
//   stb_idx_o    which update strobe to raise
//   sel_group_o  decoded group
//   sel_sub_o    decoded subslot
module jtopl_mmr_dec
  import jtopl_mmr_pkg::*;
(
  input  logic [7:0] sel_reg_i,
  output logic       valid_o,
  output logic       fnum_latch_o,
  output stb_e       stb_idx_o,
  output logic [1:0] sel_group_o,
  output logic [2:0] sel_sub_o
);

  logic op_ok;
  logic ch_ok;

  // Operator offsets: 3 groups of 6 slots, holes at x6/x7 and 0x18 upwards.
  assign op_ok = (sel_reg_i[2:0] <= 3'd5) && (sel_reg_i[4:3] <= 2'd2);
  assign ch_ok = (sel_reg_i[3:0] <= 4'd8);

  always_comb begin
    valid_o      = 1'b0;
    fnum_latch_o = 1'b0;
    stb_idx_o    = STB_MULT;
    sel_group_o  = 2'd0;
    sel_sub_o    = 3'd0;
    // Operator registers each occupy one 32-byte block, so the top three
    // address bits identify the parameter.
    if (sel_reg_i[7:5] == REG_MULT[7:5] || sel_reg_i[7:5] == REG_KSL_TL[7:5] ||
        sel_reg_i[7:5] == REG_AR_DR[7:5] || sel_reg_i[7:5] == REG_SL_RR[7:5]) begin
      valid_o     = op_ok;
      stb_idx_o   = stb_e'(sel_reg_i[7:5] - 3'd1);
      sel_group_o = sel_reg_i[4:3];
      sel_sub_o   = sel_reg_i[2:0];
    end else if (sel_reg_i[7:4] == REG_FNUM_LO[7:4]) begin
      fnum_latch_o = ch_ok;
    end else if (sel_reg_i[7:4] == REG_FNUM_HI[7:4]) begin
      valid_o     = ch_ok;
      stb_idx_o   = STB_FNUM;
      sel_group_o = ch_group(sel_reg_i[3:0]);
      sel_sub_o   = ch_sub(sel_reg_i[3:0]);
    end else if (sel_reg_i[7:4] == REG_FBCON[7:4]) begin
      valid_o     = ch_ok;
      stb_idx_o   = STB_FBCON;
      sel_group_o = ch_group(sel_reg_i[3:0]);
      sel_sub_o   = ch_sub(sel_reg_i[3:0]);
    end
  end

endmodule

// File: rtl/jtopl_mmr.sv
// jtopl_mmr
// Host-bus register decoder feeding the operator/channel register stage.
// A data write to a valid register raises one update strobe together with a
// held data byte and group/subslot selector for SWEEP cen ticks, so the
// downstream stage sees it once in every slot of a full operator sweep.
// Ports:
//   clk, rst_n       clock, asynchronous active-low reset
//   cen              clock enable shared with the downstream slot counter
//   cs_n, wr_n       host chip select / write strobe (active-low)
//   addr             0: address port, 1: data port
//   din              host data bus
//   busy             a data write is being held
//   lost             sticky: a data write was dropped while busy
//   dout             held data byte
//   sel_group/sub    held selector
//   latch_fnum       last byte written to 0xA0-0xA8
//   up_*             update strobes (at most one high)
module jtopl_mmr
  import jtopl_mmr_pkg::*;
#(
  parameter int SWEEP = SWEEP_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cen,
  input  logic       cs_n,
  input  logic       wr_n,
  input  logic       addr,
  input  logic [7:0] din,
  output logic       busy,
  output logic       lost,
  output logic [7:0] dout,
  output logic [1:0] sel_group,
  output logic [2:0] sel_sub,
  output logic [7:0] latch_fnum,
  output logic       up_mult,
  output logic       up_ksl_tl,
  output logic       up_ar_dr,
  output logic       up_sl_rr,
  output logic       up_fnum,
  output logic       up_fbcon
);

  localparam int CW = (SWEEP > 1) ? $clog2(SWEEP) : 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'(SWEEP - 1);

  typedef enum logic {ST_IDLE, ST_HOLD} state_e;

  state_e            state_q;
  logic [CW-1:0]     cnt_q;
  logic              we_prev_q;
  logic [7:0]        sel_reg_q;
  logic              lost_q;
  logic [7:0]        dout_q;
  logic [1:0]        group_q;
  logic [2:0]        sub_q;
  logic [7:0]        fnum_q;
  logic [NSTB-1:0]   up_q;

  logic              we_d;
  logic              wr_ev_d;
  logic              dec_valid;
  logic              dec_fnum;
  stb_e              dec_idx;
  logic [1:0]        dec_group;
  logic [2:0]        dec_sub;
  logic [NSTB-1:0]   dec_hot;

  // Edge detect on clk: a bus held low produces a single write event.
  assign we_d    = ~cs_n & ~wr_n;
  assign wr_ev_d = we_d & ~we_prev_q;

  jtopl_mmr_dec u_dec (
    .sel_reg_i    (sel_reg_q),
    .valid_o      (dec_valid),
    .fnum_latch_o (dec_fnum),
    .stb_idx_o    (dec_idx),
    .sel_group_o  (dec_group),
    .sel_sub_o    (dec_sub)
  );

  for (genvar gi = 0; gi < NSTB; gi++) begin : g_hot
    assign dec_hot[gi] = (dec_idx == stb_e'(gi));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      we_prev_q <= 1'b0;
      sel_reg_q <= 8'h00;
      lost_q    <= 1'b0;
      dout_q    <= 8'h00;
      group_q   <= 2'd0;
      sub_q     <= 3'd0;
      fnum_q    <= 8'h00;
      up_q      <= '0;
    end else begin
      we_prev_q <= we_d;

      // Sweep countdown; dout and selectors are left as they are on expiry.
      if (state_q == ST_HOLD && cen) begin
        if (cnt_q == '0) begin
          state_q <= ST_IDLE;
          up_q    <= '0;
        end else begin
          cnt_q <= cnt_q - 1'b1;
        end
      end

      // Busy is judged on the current state, so a data write landing on the
      // final cen tick of a hold is still dropped.
      if (wr_ev_d) begin
        if (addr) begin
          if (state_q == ST_HOLD) begin
            lost_q <= 1'b1;
          end else if (dec_fnum) begin
            fnum_q <= din;
          end else if (dec_valid) begin
            dout_q  <= din;
            group_q <= dec_group;
            sub_q   <= dec_sub;
            up_q    <= dec_hot;
            cnt_q   <= CNT_LOAD;
            state_q <= ST_HOLD;
          end
        end else begin
          sel_reg_q <= din;
          lost_q    <= 1'b0;
        end
      end
    end
  end

  assign busy       = (state_q == ST_HOLD);
  assign lost       = lost_q;
  assign dout       = dout_q;
  assign sel_group  = group_q;
  assign sel_sub    = sub_q;
  assign latch_fnum = fnum_q;
  assign up_mult    = up_q[STB_MULT];
  assign up_ksl_tl  = up_q[STB_KSL_TL];
  assign up_ar_dr   = up_q[STB_AR_DR];
  assign up_sl_rr   = up_q[STB_SL_RR];
  assign up_fnum    = up_q[STB_FNUM];
  assign up_fbcon   = up_q[STB_FBCON];

endmodule

// File: tb/tb_jtopl_mmr.sv
// Testbench for jtopl_mmr: directed scenarios plus randomized host traffic,
// all checked cycle by cycle against a behavioural model of the register map.
module tb_jtopl_mmr;

  localparam int SWEEP = 18;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cen = 1'b0;
  logic       cs_n = 1'b1;
  logic       wr_n = 1'b1;
  logic       addr = 1'b0;
  logic [7:0] din = 8'h00;
  logic       busy, lost;
  logic [7:0] dout, latch_fnum;
  logic [1:0] sel_group;
  logic [2:0] sel_sub;
  logic       up_mult, up_ksl_tl, up_ar_dr, up_sl_rr, up_fnum, up_fbcon;

  jtopl_mmr #(.SWEEP(SWEEP)) dut (
    .clk(clk), .rst_n(rst_n), .cen(cen), .cs_n(cs_n), .wr_n(wr_n),
    .addr(addr), .din(din), .busy(busy), .lost(lost), .dout(dout),
    .sel_group(sel_group), .sel_sub(sel_sub), .latch_fnum(latch_fnum),
    .up_mult(up_mult), .up_ksl_tl(up_ksl_tl), .up_ar_dr(up_ar_dr),
    .up_sl_rr(up_sl_rr), .up_fnum(up_fnum), .up_fbcon(up_fbcon)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_fail = 0;
  int cyc = 0;
  int cen_div = 4;
  int busy_cen_cnt = 0;

  // Reference model state
  int m_prev_we, m_sel, m_lost, m_fnum, m_dout, m_grp, m_sub, m_stb, m_left;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic model_reset();
    m_prev_we = 0; m_sel = 0; m_lost = 0; m_fnum = 0; m_dout = 0;
    m_grp = 0; m_sub = 0; m_stb = -1; m_left = 0;
  endtask

  // Register map rules applied to a data write while idle.
  task automatic model_data(input int r, input int d);
    int o, ch;
    if (r >= 8'h20 && r <= 8'h9F) begin
      o = r % 32;
      if ((o % 8) <= 5 && (o / 8) <= 2) begin
        m_stb = r / 32 - 1; m_grp = o / 8; m_sub = o % 8;
        m_dout = d; m_left = SWEEP;
      end
    end else if (r >= 8'hA0 && r <= 8'hA8) begin
      m_fnum = d;
    end else if ((r >= 8'hB0 && r <= 8'hB8) || (r >= 8'hC0 && r <= 8'hC8)) begin
      ch = r % 16;
      m_stb = (r >= 8'hC0) ? 5 : 4; m_grp = ch / 3; m_sub = ch % 3;
      m_dout = d; m_left = SWEEP;
    end
  endtask

  task automatic model_edge(input bit cs, input bit wr, input bit a, input bit c, input int d);
    bit we, ev, was_busy;
    if (!rst_n) begin
      model_reset();
      return;
    end
    we = !cs && !wr;
    ev = we && !m_prev_we;
    m_prev_we = we;
    was_busy = (m_left > 0);
    if (was_busy && c) begin
      m_left--;
      if (m_left == 0) m_stb = -1;
    end
    if (ev) begin
      if (!a) begin m_sel = d; m_lost = 0; end
      else if (was_busy) m_lost = 1;
      else model_data(m_sel, d);
    end
  endtask

  task automatic check_all();
    logic [5:0] got_up;
    logic [5:0] exp_up;
    got_up = {up_fbcon, up_fnum, up_sl_rr, up_ar_dr, up_ksl_tl, up_mult};
    exp_up = (m_stb >= 0) ? (6'd1 << m_stb) : 6'd0;
    check("busy", 32'(busy), 32'(m_left > 0));
    check("lost", 32'(lost), 32'(m_lost));
    check("dout", 32'(dout), 32'(m_dout));
    check("sel_group", 32'(sel_group), 32'(m_grp));
    check("sel_sub", 32'(sel_sub), 32'(m_sub));
    check("latch_fnum", 32'(latch_fnum), 32'(m_fnum));
    check("strobes", 32'(got_up), 32'(exp_up));
  endtask

  function automatic bit next_cen();
    return (cen_div != 0) && (cyc % cen_div == 0);
  endfunction

  task automatic tick(input bit cs, input bit wr, input bit a, input int d);
    bit c;
    c = next_cen();
    cs_n = cs; wr_n = wr; addr = a; din = 8'(d); cen = c;
    if (busy && c) busy_cen_cnt++;
    @(posedge clk);
    model_edge(cs, wr, a, c, d);
    cyc++;
    #1 check_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(1, 1, 0, $urandom_range(0, 255));
  endtask

  task automatic host_wr(input bit a, input int d);
    tick(0, 0, a, d);
    tick(1, 1, a, d);
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    while (m_left > 0 && k < 1000) begin idle(1); k++; end
    if (k >= 1000) check("wait_idle_timeout", 32'd0, 32'd1);
  endtask

  int regs[$] = '{8'h20, 8'h40, 8'h60, 8'h80, 8'hA0, 8'hB0, 8'hC0, 8'hE0, 8'h00};

  initial begin
    int k;
    model_reset();
    // Reset held for a few cycles, outputs at reset values.
    rst_n = 1'b0;
    idle(3);
    rst_n = 1'b1;
    idle(2);

    // Operator write 0x2D <- 0x21: MULT, group 1, subslot 5, held 18 cen ticks.
    cen_div = 4;
    host_wr(0, 8'h2D);
    busy_cen_cnt = 0;
    tick(0, 0, 1, 8'h21);
    check("mult_up", 32'(up_mult), 32'd1);
    check("mult_grp", 32'(sel_group), 32'd1);
    check("mult_sub", 32'(sel_sub), 32'd5);
    tick(1, 1, 1, 8'h21);
    wait_idle();
    check("sweep_len", 32'(busy_cen_cnt), 32'(SWEEP));
    idle(3);

    // F-number low latch, then F-number high on channel 4.
    host_wr(0, 8'hA4); host_wr(1, 8'h57);
    check("fnum_latch", 32'(latch_fnum), 32'h57);
    check("fnum_nobusy", 32'(busy), 32'd0);
    host_wr(0, 8'hB4); host_wr(1, 8'h2E);
    check("fnum_up", 32'(up_fnum), 32'd1);
    check("fnum_dout", 32'(dout), 32'h2E);
    wait_idle();

    // Invalid offsets are ignored.
    foreach (regs[i]) begin end
    for (int i = 0; i < 4; i++) begin
      int bad[4] = '{8'h26, 8'h38, 8'hB9, 8'hE0};
      host_wr(0, bad[i]); host_wr(1, 8'hFF);
      idle(2);
      check("invalid_nobusy", 32'(busy), 32'd0);
    end

    // Data write during hold is dropped; address write clears lost.
    host_wr(0, 8'hC7); host_wr(1, 8'h3C);
    idle(5);
    host_wr(1, 8'h99);
    check("hold_lost", 32'(lost), 32'd1);
    check("hold_dout", 32'(dout), 32'h3C);
    host_wr(0, 8'h61);
    check("lost_clear", 32'(lost), 32'd0);
    wait_idle();

    // wr_n held low 50 clocks on the data port: one strobe only.
    host_wr(0, 8'h8A);
    for (int i = 0; i < 50; i++) tick(0, 0, 1, 8'h44);
    tick(1, 1, 1, 8'h44);
    // Align a data write with the final cen tick of the hold.
    k = 0;
    while (!(m_left == 1 && next_cen()) && k < 500) begin idle(1); k++; end
    if (k >= 500) check("align_timeout", 32'd0, 32'd1);
    tick(0, 0, 1, 8'h77);
    check("final_tick_lost", 32'(lost), 32'd1);
    check("final_tick_idle", 32'(busy), 32'd0);
    tick(1, 1, 1, 8'h77);
    idle(3);

    // Asynchronous reset in the middle of a hold.
    host_wr(0, 8'h52); host_wr(1, 8'hA5);
    idle(6);
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all();
    idle(2);
    rst_n = 1'b1;
    idle(2);

    // Randomized traffic with varying cen ratios (including cen stuck low).
    for (int seg = 0; seg < 15; seg++) begin
      int divs[6] = '{1, 2, 3, 4, 7, 0};
      cen_div = divs[$urandom_range(0, 5)];
      for (int i = 0; i < 150; i++) begin
        int r;
        r = $urandom_range(0, 99);
        if (r < 50) begin
          idle(1);
        end else if (r < 70) begin
          if ($urandom_range(0, 4) == 0) host_wr(0, $urandom_range(0, 255));
          else host_wr(0, regs[$urandom_range(0, regs.size() - 1)] + $urandom_range(0, 23));
        end else begin
          int hold;
          hold = $urandom_range(1, 3);
          for (int h = 0; h < hold; h++) tick(0, 0, 1, $urandom_range(0, 255));
          tick(1, 1, 1, 0);
        end
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
